icosoc_raspif_master: RTL
=========================

Name: icosoc_raspif_master

Overview:
- Host-side (initiator) end of the 9-line RasPi parallel link: drives link clock, direction and data lines as the Raspberry Pi does toward the FPGA-side endpoint bridge.
- Converts a local (ep, byte) transmit stream into endpoint-select commands plus data words, and polls the far end for returned (ep, byte) words.
- Used for FPGA-to-FPGA bridging and as a synthesizable link exerciser in loopback benches.

Parameters:
- CLKDIV, 4, system clocks per link-clock half period (min 2).
- TURN_CYCLES, 4, system clocks with data lines released on each direction change (min 1).
- POLL, 1, 1: issue read cycles automatically whenever idle and rx has space; 0: read only while rd_req=1.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous reset, active low
- tx_valid  in  1  transmit word valid
- tx_ready  out  1  transmit word accepted this cycle
- tx_ep  in  8  destination endpoint (0xff = sync/trigger endpoint)
- tx_data  in  8  data byte
- rx_valid  out  1  received word valid
- rx_ready  in  1  consumer accepts received word
- rx_ep  out  8  source endpoint of received word
- rx_data  out  8  received byte
- rd_req  in  1  request read cycles (used when POLL=0)
- remote_pending  out  1  last read status word was 9'h1fe (far end still holds undelivered data from us)
- link_clk  out  1  link clock
- link_dir  out  1  1 = master drives data lines, 0 = far end drives
- link_dout  out  9  data lines out; bit 8 set = command
- link_oe  out  1  data line output enable
- link_din  in  9  data lines in

Behaviour:
- Reset (resetn=0 at posedge clk): link_clk=0, link_dir=1, link_oe=0, link_dout=0, tx_ready=0, rx_valid=0, remote_pending=0, tx_cur_ep invalid, rx_cur_ep=0xff, FSM->IDLE. Reset mid-transfer abandons the word; link_clk drops low in the same cycle.
- Link cycle: link_clk low for CLKDIV clocks, then high for CLKDIV clocks. link_dout changes only at the start of a low phase. link_din is sampled on the last clock of a low phase, immediately before link_clk rises.
- FSM: IDLE, WR_CMD, WR_DATA, TURN_TO_RD, RD, TURN_TO_WR.
- IDLE, link_dir=1: tx_valid has priority.
  - If tx_cur_ep is invalid or != tx_ep -> WR_CMD.
  - Else -> WR_DATA.
  - Else, if a read is wanted (POLL=1 or rd_req=1) and the rx slot is empty -> TURN_TO_RD.
- WR_CMD: link_oe=1; drive {1,tx_ep} for one link cycle; tx_cur_ep<=tx_ep; -> WR_DATA.
- WR_DATA: drive {0,tx_data} for one link cycle.
  - tx_ready=1 for exactly one clock, on the clock link_clk rises.
  - Then -> IDLE.
- TURN_TO_RD: link_oe=0 immediately; after TURN_CYCLES set link_dir=0; wait a further TURN_CYCLES; -> RD.
- RD: one link cycle per word; a link_clk rising edge is generated only while the rx slot is empty.
  - Sample with bit 8=1 -> rx_cur_ep<=din[7:0]; remote_pending<=(din==9'h1fe). No rx output.
  - Sample with bit 8=0 -> load rx slot {rx_cur_ep, din[7:0]}; rx_valid=1 until rx_ready handshake.
  - Exit to TURN_TO_WR on:
    - a status sample 9'h1fe or 9'h1ff, or
    - tx_valid=1 (once the current link cycle completes), or
    - no read wanted.
- TURN_TO_WR: set link_dir=1; wait TURN_CYCLES; link_oe=1; -> IDLE. link_oe and link_dir=0 are never both asserted.
- tx_cur_ep becomes invalid on every TURN_TO_RD, so the first write after a read phase always re-sends the endpoint command.
- rx slot depth is 1. With rx_valid=1 and rx_ready=0 the master holds link_clk low (no pop on the far end).

Optional Feature:
- Macro: ICOSOC_RASPIF_MASTER_STATS_EN.
- Defined: adds outputs tx_count[15:0] and rx_count[15:0], both reset to 0.
  - tx_count increments per accepted tx word (commands excluded).
  - rx_count increments per loaded rx data word.
  - Both wrap 0xffff->0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- tx (ep=2, 0x55) then (ep=2, 0xaa) -> link sees 0x102, 0x055, 0x0aa on link_clk rising edges; one command only; tx_ready pulses twice.
- tx (ep=1, 0x11) then (ep=3, 0x33) -> 0x101, 0x011, 0x103, 0x033.
- Read phase with far end returning 0x104, 0x07e, 0x07f, 0x1ff -> rx words (4, 0x7e), (4, 0x7f); exit on 0x1ff; remote_pending=0.
- rx_ready held 0 after first rx word -> link_clk stays low; no further rising edges until the handshake.
- Direction change in both directions -> link_oe=0 for at least TURN_CYCLES around every link_dir edge; never link_oe=1 with link_dir=0.
- Assert resetn=0 during WR_DATA -> next clock: link_clk=0, link_oe=0, tx_ready=0; the next write after reset begins with an endpoint command.

Source files
------------

// File: rtl/icosoc_raspif_master.sv
// Initiator end of the 9-line RasPi parallel link: endpoint-select writes plus polled reads.
// Optional ICOSOC_RASPIF_MASTER_STATS_EN adds tx_count/rx_count word counters.
module icosoc_raspif_master #(
    parameter int unsigned CLKDIV      = 4,
    parameter int unsigned TURN_CYCLES = 4,
    parameter bit          POLL        = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_ep,
    input  logic [7:0] tx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_ep,
    output logic [7:0] rx_data,
    input  logic       rd_req,
    output logic       remote_pending,
    output logic       link_clk,
    output logic       link_dir,
    output logic [8:0] link_dout,
    output logic       link_oe,
    input  logic [8:0] link_din
`ifdef ICOSOC_RASPIF_MASTER_STATS_EN
    ,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count
`endif
);

    localparam int unsigned CNT_MAX = (CLKDIV > TURN_CYCLES) ? 2 * CLKDIV : 2 * TURN_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] LOW_LAST  = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] HIGH_LAST = CW'(2 * CLKDIV - 1);
    localparam logic [CW-1:0] TURN_MID  = CW'(TURN_CYCLES - 1);
    localparam logic [CW-1:0] TURN_END  = CW'(2 * TURN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CMD,
        S_WR_DATA,
        S_TURN_TO_RD,
        S_RD,
        S_TURN_TO_WR
    } state_t;

    state_t        state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    logic          nxt_link_clk, nxt_link_dir, nxt_link_oe;
    logic [8:0]    nxt_link_dout;
    logic          nxt_tx_ready, nxt_rx_valid, nxt_remote_pending;
    logic [7:0]    nxt_rx_ep, nxt_rx_data;
    logic [7:0]    tx_cur_ep, nxt_tx_cur_ep;
    logic          tx_cur_vld, nxt_tx_cur_vld;
    logic [7:0]    rx_cur_ep, nxt_rx_cur_ep;
    logic          rd_stop, nxt_rd_stop;
    logic          rd_want_c;
    logic          rx_load_c;

    assign rd_want_c = POLL | rd_req;

    // Next-state and next-output logic; every output register is loaded from here.
    always_comb begin
        nxt_state          = state;
        nxt_cnt            = cnt;
        nxt_link_clk       = link_clk;
        nxt_link_dir       = link_dir;
        nxt_link_oe        = link_oe;
        nxt_link_dout      = link_dout;
        nxt_tx_ready       = 1'b0;
        nxt_rx_valid       = rx_valid;
        nxt_rx_ep          = rx_ep;
        nxt_rx_data        = rx_data;
        nxt_remote_pending = remote_pending;
        nxt_tx_cur_ep      = tx_cur_ep;
        nxt_tx_cur_vld     = tx_cur_vld;
        nxt_rx_cur_ep      = rx_cur_ep;
        nxt_rd_stop        = rd_stop;
        rx_load_c          = 1'b0;

        if (rx_valid && rx_ready) begin
            nxt_rx_valid = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (tx_valid) begin
                    nxt_cnt      = '0;
                    nxt_link_clk = 1'b0;
                    nxt_link_oe  = 1'b1;
                    if (!tx_cur_vld || (tx_cur_ep != tx_ep)) begin
                        nxt_state     = S_WR_CMD;
                        nxt_link_dout = {1'b1, tx_ep};
                    end else begin
                        nxt_state     = S_WR_DATA;
                        nxt_link_dout = {1'b0, tx_data};
                    end
                end else if (rd_want_c && !rx_valid) begin
                    nxt_state      = S_TURN_TO_RD;
                    nxt_link_oe    = 1'b0;
                    nxt_cnt        = '0;
                    nxt_tx_cur_vld = 1'b0;
                end
            end

            S_WR_CMD: begin
                if (cnt == LOW_LAST) begin
                    nxt_link_clk = 1'b1;
                    nxt_cnt      = cnt + CW'(1);
                end else if (cnt == HIGH_LAST) begin
                    nxt_tx_cur_ep  = tx_ep;
                    nxt_tx_cur_vld = 1'b1;
                    nxt_state      = S_WR_DATA;
                    nxt_link_dout  = {1'b0, tx_data};
                    nxt_link_clk   = 1'b0;
                    nxt_cnt        = '0;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end

            S_WR_DATA: begin
                if (cnt == LOW_LAST) begin
                    nxt_link_clk = 1'b1;
                    nxt_tx_ready = 1'b1;
                    nxt_cnt      = cnt + CW'(1);
                end else if (cnt == HIGH_LAST) begin
                    nxt_link_clk = 1'b0;
                    nxt_cnt      = '0;
                    nxt_state    = S_IDLE;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end

            S_TURN_TO_RD: begin
                if (cnt == TURN_MID) begin
                    nxt_link_dir = 1'b0;
                end
                if (cnt == TURN_END) begin
                    nxt_state    = S_RD;
                    nxt_cnt      = '0;
                    nxt_link_clk = 1'b0;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end

            S_RD: begin
                if (cnt == LOW_LAST) begin
                    // A full rx slot holds link_clk low so the far end does not pop.
                    if (rx_valid) begin
                        if (tx_valid || !rd_want_c) begin
                            nxt_state    = S_TURN_TO_WR;
                            nxt_link_dir = 1'b1;
                            nxt_cnt      = '0;
                        end
                    end else begin
                        nxt_link_clk = 1'b1;
                        nxt_cnt      = cnt + CW'(1);
                        if (link_din[8]) begin
                            nxt_rx_cur_ep      = link_din[7:0];
                            nxt_remote_pending = (link_din == 9'h1fe);
                            nxt_rd_stop        = (link_din[7:1] == 7'h7f);
                        end else begin
                            rx_load_c    = 1'b1;
                            nxt_rx_valid = 1'b1;
                            nxt_rx_ep    = rx_cur_ep;
                            nxt_rx_data  = link_din[7:0];
                            nxt_rd_stop  = 1'b0;
                        end
                    end
                end else if (cnt == HIGH_LAST) begin
                    nxt_link_clk = 1'b0;
                    nxt_cnt      = '0;
                    if (rd_stop || tx_valid || !rd_want_c) begin
                        nxt_state    = S_TURN_TO_WR;
                        nxt_link_dir = 1'b1;
                    end
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end

            S_TURN_TO_WR: begin
                if (cnt == TURN_MID) begin
                    nxt_state   = S_IDLE;
                    nxt_link_oe = 1'b1;
                    nxt_cnt     = '0;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end

            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= S_IDLE;
            cnt            <= '0;
            link_clk       <= 1'b0;
            link_dir       <= 1'b1;
            link_oe        <= 1'b0;
            link_dout      <= '0;
            tx_ready       <= 1'b0;
            rx_valid       <= 1'b0;
            rx_ep          <= '0;
            rx_data        <= '0;
            remote_pending <= 1'b0;
            tx_cur_ep      <= '0;
            tx_cur_vld     <= 1'b0;
            rx_cur_ep      <= 8'hff;
            rd_stop        <= 1'b0;
        end else begin
            state          <= nxt_state;
            cnt            <= nxt_cnt;
            link_clk       <= nxt_link_clk;
            link_dir       <= nxt_link_dir;
            link_oe        <= nxt_link_oe;
            link_dout      <= nxt_link_dout;
            tx_ready       <= nxt_tx_ready;
            rx_valid       <= nxt_rx_valid;
            rx_ep          <= nxt_rx_ep;
            rx_data        <= nxt_rx_data;
            remote_pending <= nxt_remote_pending;
            tx_cur_ep      <= nxt_tx_cur_ep;
            tx_cur_vld     <= nxt_tx_cur_vld;
            rx_cur_ep      <= nxt_rx_cur_ep;
            rd_stop        <= nxt_rd_stop;
        end
    end

`ifdef ICOSOC_RASPIF_MASTER_STATS_EN
    // Data-word counters, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_count <= '0;
            rx_count <= '0;
        end else begin
            if (nxt_tx_ready) begin
                tx_count <= tx_count + 16'd1;
            end
            if (rx_load_c) begin
                rx_count <= rx_count + 16'd1;
            end
        end
    end
`else
    // Statistics counters not built.
`endif

endmodule
